bridge_mmio: RTL and testbench
==============================

Name: bridge_mmio

Overview:
- Parametrised system bridge between the CPU memory stage and data memory plus NDEV memory-mapped peripherals.
- Memory accesses stay zero-wait and combinational.
- Device accesses run through a registered request/ready handshake with stall, timeout and bus-error reporting.
- Device interrupt lines are synchronised and presented as HWInt to CP0.

Parameters:
- NDEV, 2: number of peripheral slots (legal 1..6).
- DATA_BEGIN, 32'h0000_0000: first byte address of data memory.
- DATA_END, 32'h0000_2FFF: last byte address of data memory.
- DEV_BASE, 32'h0000_7F00: base address of slot 0.
- DEV_STRIDE, 32'h10: byte spacing between slots; slot i spans DEV_BASE+i*DEV_STRIDE .. +DEV_STRIDE-1.
- TIMEOUT, 16: maximum BUSY cycles before abort (legal >=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- PrAddr  in  32  CPU byte address
- PrReq  in  1  CPU access valid; held high until PrStall is low
- PrWE  in  1  CPU write
- PrBE  in  4  byte enables
- PrWD  in  32  write data
- PrRD  out  32  read data to CPU
- PrStall  out  1  freeze CPU pipeline
- PrErr  out  1  one-cycle bus error (unmapped address or timeout)
- MEMWE  out  1  data-memory write enable
- MEMRD  in  32  data-memory read data
- Addr  out  32  address to memory/devices
- BE  out  4  byte enables to memory/devices
- WD  out  32  write data to memory/devices
- DevSel  out  NDEV  one-hot device select
- DevWE  out  1  device write strobe
- DevRD  in  32*NDEV  device read data; slot i at bits [32i+31:32i]
- DevReady  in  NDEV  per-device access complete
- DevIrq  in  NDEV  asynchronous device interrupt levels
- HWInt  out  6  interrupt vector to CP0

Behaviour:
- Address decode:
  - MEMHIT = DATA_BEGIN <= PrAddr <= DATA_END.
  - DEVHIT[i] = slot-i range.
  - MEMHIT takes priority over DEVHIT.
  - Neither hit = unmapped.
- Memory path, state IDLE:
  - Addr, BE and WD pass PrAddr, PrBE and PrWD straight through.
  - MEMWE = PrReq & PrWE & MEMHIT.
  - PrRD = MEMRD.
  - No stall.
- Unmapped path with PrReq in IDLE:
  - PrRD = 0, PrErr = 1 in the same cycle.
  - No stall; no write strobe of any kind.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on PrReq & any DEVHIT:
  - PrStall = 1 combinationally in that cycle.
  - Latch addr, BE, WD, WE and slot index into registers; clear cycle counter.
- BUSY:
  - Addr, BE and WD come from the latched registers.
  - DevSel = onehot(index); DevWE = latched WE.
  - PrStall = 1; counter increments each cycle.
- BUSY -> DONE when DevReady[index] = 1:
  - Capture DevRD slot into rdata; err = 0.
- BUSY -> DONE on timeout, when the counter reaches TIMEOUT-1 without ready:
  - rdata = 0; err = 1.
- DONE:
  - DevSel = 0, DevWE = 0, PrStall = 0.
  - PrRD = rdata; PrErr = err for exactly this cycle.
  - Unconditionally -> IDLE. The still-high PrReq in DONE is consumed and does not start a new access.
- DevReady on a non-selected slot, or while in IDLE/DONE, is ignored.
- Minimum device access: 2 stall cycles plus the DONE cycle.
- Interrupts:
  - Each DevIrq passes through a 2-flop synchroniser.
  - HWInt[NDEV-1:0] = synchronised levels; HWInt[5:NDEV] = 0.
  - Latency is 2 clk edges; HWInt is level, not latched.
- Reset, asynchronous, including mid-transaction:
  - FSM = IDLE; counter = 0; rdata = 0; err = 0; synchronisers = 0.
  - Therefore DevSel = 0, DevWE = 0, PrStall = 0, PrErr = 0, HWInt = 0.
  - An aborted device write is not retried.
- Counter width = clog2(TIMEOUT)+1; it does not wrap within a transaction.

Test Plan:
1. Memory read/write: PrReq=1, PrWE=1, PrAddr=0x0000_0010, PrBE=4'hF, PrWD=0xDEADBEEF -> MEMWE=1, PrStall=0, DevSel=0 same cycle. Read with MEMRD=0x1234 -> PrRD=0x1234.
2. Device 1 write with 3-cycle ready delay: PrAddr=0x7F14, PrWE=1, PrWD=0xA5 -> PrStall high for 4 cycles. DevSel=2'b10 and DevWE=1 during BUSY with WD=0xA5. DONE cycle has PrStall=0 and PrErr=0; FSM then returns to IDLE with no second access.
3. Device 0 read, ready in first BUSY cycle, DevRD slot0=0xCAFE -> exactly 2 stall cycles, then PrRD=0xCAFE in DONE.
4. Timeout: TIMEOUT=16, device 0 read with DevReady never asserted -> PrStall for 17 cycles (IDLE + 16 BUSY), then DONE with PrRD=0 and PrErr=1 for 1 cycle.
5. Unmapped: PrAddr=0x0000_5000, PrReq=1, PrWE=1 -> PrErr=1, PrRD=0, MEMWE=0, DevSel=0, PrStall=0 in the same cycle.
6. Interrupts and reset: DevIrq=2'b01 -> HWInt=6'b000001 after 2 edges. Assert reset in BUSY -> immediately DevSel=0, PrStall=0, HWInt=0; after release, FSM is IDLE.

Source files
------------

// File: rtl/bridge_mmio.sv
// rtl/bridge_mmio.sv - CPU to data-memory / memory-mapped peripheral bridge
// Memory is zero-wait; device slots use a registered request/ready handshake with timeout.
module bridge_mmio #(
  parameter int          NDEV       = 2,
  parameter logic [31:0] DATA_BEGIN = 32'h0000_0000,
  parameter logic [31:0] DATA_END   = 32'h0000_2FFF,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
  parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
  parameter int          TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PrAddr,
  input  logic                 PrReq,
  input  logic                 PrWE,
  input  logic [3:0]           PrBE,
  input  logic [31:0]          PrWD,
  output logic [31:0]          PrRD,
  output logic                 PrStall,
  output logic                 PrErr,
  output logic                 MEMWE,
  input  logic [31:0]          MEMRD,
  output logic [31:0]          Addr,
  output logic [3:0]           BE,
  output logic [31:0]          WD,
  output logic [NDEV-1:0]      DevSel,
  output logic                 DevWE,
  input  logic [32*NDEV-1:0]   DevRD,
  input  logic [NDEV-1:0]      DevReady,
  input  logic [NDEV-1:0]      DevIrq,
  output logic [5:0]           HWInt
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     addr_q, wd_q, rdata_q;
  logic [3:0]      be_q;
  logic            we_q, err_q;
  logic [IW-1:0]   idx_q, hit_idx;
  logic [CW-1:0]   cnt_q;
  logic [NDEV-1:0] dev_hit, irq_s1, irq_s2;
  logic            mem_hit, dev_any, ready_sel, timeout;
  logic [31:0]     dev_rd_sel;

  // Range checks use unsigned offsets so a region starting at 0 needs no special case.
  always_comb begin
    mem_hit = (PrAddr - DATA_BEGIN) <= (DATA_END - DATA_BEGIN);
    dev_hit = '0;
    hit_idx = '0;
    for (int i = 0; i < NDEV; i++) begin
      if ((PrAddr - DEV_BASE - 32'(i) * DEV_STRIDE) < DEV_STRIDE) begin
        dev_hit[i] = 1'b1;
        hit_idx    = IW'(i);
      end
    end
    dev_any = (|dev_hit) && !mem_hit;
  end

  assign ready_sel  = DevReady[idx_q];
  assign dev_rd_sel = DevRD[32*idx_q +: 32];
  assign timeout    = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    Addr      = PrAddr;
    BE        = PrBE;
    WD        = PrWD;
    MEMWE     = 1'b0;
    PrRD      = '0;
    PrStall   = 1'b0;
    PrErr     = 1'b0;
    DevSel    = '0;
    DevWE     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_hit) begin
          MEMWE = PrReq & PrWE;
          PrRD  = MEMRD;
        end else if (dev_any) begin
          if (PrReq) begin
            PrStall   = 1'b1;
            state_nxt = BUSY;
          end
        end else begin
          PrErr = PrReq;
        end
      end
      BUSY: begin
        Addr    = addr_q;
        BE      = be_q;
        WD      = wd_q;
        DevSel  = NDEV'(1) << idx_q;
        DevWE   = we_q;
        PrStall = 1'b1;
        if (ready_sel || timeout) state_nxt = DONE;
      end
      DONE: begin
        // PrReq is still high here but belongs to the finished access.
        PrRD      = rdata_q;
        PrErr     = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (PrReq && dev_any) begin
            addr_q <= PrAddr;
            wd_q   <= PrWD;
            be_q   <= PrBE;
            we_q   <= PrWE;
            idx_q  <= hit_idx;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (ready_sel) begin
            rdata_q <= dev_rd_sel;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      irq_s1 <= DevIrq;
      irq_s2 <= irq_s1;
    end
  end

  always_comb begin
    HWInt            = '0;
    HWInt[NDEV-1:0]  = irq_s2;
  end

endmodule

// File: tb/tb_bridge_mmio.sv
// tb/tb_bridge_mmio.sv - directed self-checking bench for bridge_mmio
module tb_bridge_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PrAddr, PrWD, PrRD, MEMRD, Addr, WD;
  logic        PrReq, PrWE, PrStall, PrErr, MEMWE, DevWE;
  logic [3:0]  PrBE, BE;
  logic [1:0]  DevSel, DevReady, DevIrq;
  logic [63:0] DevRD;
  logic [5:0]  HWInt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bridge_mmio dut (
    .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrReq(PrReq), .PrWE(PrWE),
    .PrBE(PrBE), .PrWD(PrWD), .PrRD(PrRD), .PrStall(PrStall), .PrErr(PrErr),
    .MEMWE(MEMWE), .MEMRD(MEMRD), .Addr(Addr), .BE(BE), .WD(WD),
    .DevSel(DevSel), .DevWE(DevWE), .DevRD(DevRD), .DevReady(DevReady),
    .DevIrq(DevIrq), .HWInt(HWInt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dev_access(input string tag, input logic [31:0] addr, input logic we,
                            input logic [31:0] wd, input int dly, input int slot,
                            input int exp_stall, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    PrAddr = addr; PrWE = we; PrWD = wd; PrBE = 4'hF; PrReq = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dly == 0) DevReady = ~(2'b01 << slot);
      else          DevReady = (i == dly) ? (2'b01 << slot) : 2'b00;
      if (i == 1) PrWD = 32'h0;
      #2;
      if (PrStall) begin
        n++;
        if (i == 1) begin
          chk({tag, "_busy_devsel"}, DevSel, 2'b01 << slot);
          chk({tag, "_busy_devwe"}, DevWE, we);
          chk({tag, "_busy_wd"}, WD, wd);
          chk({tag, "_busy_addr"}, Addr, addr);
        end
      end else begin
        done = 1'b1;
        chk({tag, "_stall_cycles"}, n, exp_stall);
        chk({tag, "_done_rd"}, PrRD, exp_rd);
        chk({tag, "_done_err"}, PrErr, exp_err);
        chk({tag, "_done_devsel"}, DevSel, 0);
        chk({tag, "_done_devwe"}, DevWE, 0);
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_completed"}, done, 1);
    PrReq = 1'b0; DevReady = 2'b00;
    #2;
    chk({tag, "_after_stall"}, PrStall, 0);
    chk({tag, "_after_devsel"}, DevSel, 0);
    chk({tag, "_after_err"}, PrErr, 0);
    step();
  endtask

  initial begin
    reset = 1'b1; PrAddr = '0; PrReq = 1'b0; PrWE = 1'b0; PrBE = 4'h0; PrWD = '0;
    MEMRD = '0; DevRD = {32'h0000_1111, 32'h0000_CAFE}; DevReady = 2'b00; DevIrq = 2'b00;
    step();
    step();
    chk("rst_devsel", DevSel, 0);
    chk("rst_stall", PrStall, 0);
    chk("rst_err", PrErr, 0);
    chk("rst_hwint", HWInt, 0);
    reset = 1'b0;
    step();

    PrReq = 1'b1; PrWE = 1'b1; PrAddr = 32'h10; PrBE = 4'hF; PrWD = 32'hDEAD_BEEF;
    #2;
    chk("mem_wr_memwe", MEMWE, 1);
    chk("mem_wr_stall", PrStall, 0);
    chk("mem_wr_devsel", DevSel, 0);
    chk("mem_wr_wd", WD, 32'hDEAD_BEEF);
    chk("mem_wr_addr", Addr, 32'h10);
    PrWE = 1'b0; MEMRD = 32'h1234;
    #1;
    chk("mem_rd_prrd", PrRD, 32'h1234);
    chk("mem_rd_memwe", MEMWE, 0);
    PrWE = 1'b1; PrAddr = 32'h2FFF;
    #1;
    chk("mem_end_memwe", MEMWE, 1);
    chk("mem_end_err", PrErr, 0);
    PrAddr = 32'h3000;
    #1;
    chk("past_end_err", PrErr, 1);
    chk("past_end_memwe", MEMWE, 0);
    step();

    PrAddr = 32'h5000; PrReq = 1'b1; PrWE = 1'b1;
    #2;
    chk("unmap_err", PrErr, 1);
    chk("unmap_rd", PrRD, 0);
    chk("unmap_memwe", MEMWE, 0);
    chk("unmap_devsel", DevSel, 0);
    chk("unmap_stall", PrStall, 0);
    chk("unmap_devwe", DevWE, 0);
    PrAddr = 32'h7F20;
    #1;
    chk("past_dev_err", PrErr, 1);
    chk("past_dev_stall", PrStall, 0);
    PrReq = 1'b0;
    step();

    dev_access("dev1_wr", 32'h7F14, 1'b1, 32'hA5, 3, 1, 4, 32'h1111, 1'b0);
    dev_access("dev0_rd", 32'h7F00, 1'b0, 32'h0, 1, 0, 2, 32'hCAFE, 1'b0);
    dev_access("dev0_tmo", 32'h7F04, 1'b0, 32'h0, 0, 0, 17, 32'h0, 1'b1);

    DevIrq = 2'b01;
    step();
    chk("irq_one_edge", HWInt, 0);
    step();
    chk("irq_two_edges", HWInt, 6'b000001);

    PrAddr = 32'h7F14; PrWE = 1'b1; PrWD = 32'h5A; PrReq = 1'b1;
    step();
    step();
    chk("rst_pre_devsel", DevSel, 2'b10);
    reset = 1'b1; PrReq = 1'b0;
    #1;
    chk("rst_mid_devsel", DevSel, 0);
    chk("rst_mid_stall", PrStall, 0);
    chk("rst_mid_hwint", HWInt, 0);
    chk("rst_mid_devwe", DevWE, 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_stall", PrStall, 0);
    chk("post_rst_devsel", DevSel, 0);
    PrAddr = 32'h20; PrReq = 1'b1;
    #1;
    chk("post_rst_idle_memwe", MEMWE, 1);
    PrReq = 1'b0;
    step();
    step();
    chk("post_rst_hwint", HWInt, 6'b000001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
